cordic_rotator: RTL and testbench

Iterative CORDIC engine that converts a phase word into first-quadrant cosine/sine magnitudes plus a 2-bit quarter code. It sits directly upstream of the quarter selector, which applies the sign and offset-binary mapping. One phase is accepted at a time through a valid/ready handshake. The result appears after a fixed number of micro-rotations, is held, and is flagged with a one-cycle strobe.

---
 rtl/cordic_pkg.sv | 41 ++++
 rtl/cordic_microrotation.sv | 30 +++
 rtl/cordic_rotator.sv | 123 ++++++++++++
 tb/tb_cordic_rotator.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC types and constants: FSM state, quarter code, arctangent table, gain-scaled x0.
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_FINISH = 2'd2
    } cordic_state_t;

    // Quarter of the turn, passed to the downstream quarter selector.
    typedef logic [1:0] quarter_t;

    // round(atan(2^-i) * 2^16 / 2pi): arctangent table for a 16-bit turn.
    localparam logic [15:0] ATAN [16] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
    };

    // CORDIC gain compensation 1/K = 0.6072529350 in Q30.
    localparam longint INV_GAIN_Q30 = 64'd652032874;

    // Table entry rescaled to a pw-bit turn (exact at pw=16).
    function automatic logic [31:0] atan_entry(input int i, input int pw);
        logic [31:0] v;
        if (i > 15) return 32'd0;
        v = 32'(ATAN[i]);
        if (pw == 16) return v;
        if (pw < 16)  return (v + (32'd1 << (15 - pw))) >> (16 - pw);
        return v << (pw - 16);
    endfunction

    // round(peak * (1/K) * 2^guard), the x0 that makes the final vector land on the peak.
    function automatic longint cordic_x0(input int dw, input int guard);
        longint peak;
        peak = (longint'(1) << (dw - 1)) - 1;
        return (((peak * INV_GAIN_Q30) << guard) + (longint'(1) << 29)) >>> 30;
    endfunction

    localparam longint CORDIC_X0 = cordic_x0(12, 2);  // 4972

endpackage

// File: rtl/cordic_microrotation.sv
// One combinational CORDIC micro-rotation in rotation mode; direction follows the sign of z.
module cordic_microrotation #(
    parameter int XW = 16,
    parameter int ZW = 16,
    parameter int IW = 4
) (
    input  logic signed [XW-1:0] i_x,
    input  logic signed [XW-1:0] i_y,
    input  logic signed [ZW-1:0] i_z,
    input  logic        [IW-1:0] i_iter,
    input  logic signed [ZW-1:0] i_atan,
    output logic signed [XW-1:0] o_x,
    output logic signed [XW-1:0] o_y,
    output logic signed [ZW-1:0] o_z
);
    logic signed [XW-1:0] w_xs;
    logic signed [XW-1:0] w_ys;
    logic                 w_pos;

    assign w_xs  = i_x >>> i_iter;
    assign w_ys  = i_y >>> i_iter;
    assign w_pos = ~i_z[ZW-1];

    // d=+1 when z>=0 rotates counter-clockwise, otherwise clockwise.
    always_comb begin
        o_x = w_pos ? (i_x - w_ys)   : (i_x + w_ys);
        o_y = w_pos ? (i_y + w_xs)   : (i_y - w_xs);
        o_z = w_pos ? (i_z - i_atan) : (i_z + i_atan);
    end
endmodule

// File: rtl/cordic_rotator.sv
// Iterative CORDIC: phase word -> first-quadrant |cos|/|sin| magnitudes plus quarter code.
module cordic_rotator
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH  = 12,
    parameter int PHASE_WIDTH = 16,
    parameter int ITERATIONS  = 12,
    parameter int GUARD       = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [PHASE_WIDTH-1:0]       phase_in,
    input  logic                         phase_valid,
    output logic                         phase_ready,
    output logic signed [DATA_WIDTH:0]   x_out,
    output logic signed [DATA_WIDTH:0]   y_out,
    output quarter_t                     quarter_out,
    output logic                         out_valid
);
    localparam int XW = DATA_WIDTH + GUARD + 2;
    localparam int ZW = PHASE_WIDTH;
    localparam int IW = $clog2(PHASE_WIDTH);
    localparam logic signed [XW-1:0] X0   = XW'(cordic_x0(DATA_WIDTH, GUARD));
    localparam logic signed [XW:0]   RND  = (GUARD > 0) ? (XW+1)'(1 << (GUARD - 1)) : '0;
    localparam logic signed [XW:0]   PEAK = (XW+1)'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic [IW-1:0]        LAST = IW'(ITERATIONS - 1);
    localparam logic signed [ZW-1:0] QTURN = ZW'(1 << (PHASE_WIDTH - 2));

    cordic_state_t              r_state;
    logic                       r_ready;
    quarter_t                   r_q;
    logic signed [XW-1:0]       r_x, r_y;
    logic signed [ZW-1:0]       r_z;
    logic [IW-1:0]              r_iter;
    logic signed [DATA_WIDTH:0] r_xo, r_yo;
    quarter_t                   r_qo;
    logic                       r_ov;

    logic signed [ZW-1:0]       w_r, w_z0, w_atan, w_zn;
    logic signed [XW-1:0]       w_xn, w_yn;
    logic signed [DATA_WIDTH:0] w_xsat, w_ysat;

    // Odd quarters fold to 90deg-r so the selector's sign rules yield cos/sin directly;
    // r=0 gives exactly 2^(PW-2), which still fits the signed z register.
    assign w_r    = ZW'(phase_in[PHASE_WIDTH-3:0]);
    assign w_z0   = phase_in[PHASE_WIDTH-2] ? (QTURN - w_r) : w_r;
    assign w_atan = ZW'(atan_entry(int'(r_iter), PHASE_WIDTH));

    cordic_microrotation #(.XW(XW), .ZW(ZW), .IW(IW)) u_rot (
        .i_x(r_x), .i_y(r_y), .i_z(r_z), .i_iter(r_iter), .i_atan(w_atan),
        .o_x(w_xn), .o_y(w_yn), .o_z(w_zn)
    );

    // Drop guard bits with round-half-up, then clamp to [0, peak].
    function automatic logic signed [DATA_WIDTH:0] round_sat(input logic signed [XW-1:0] v);
        logic signed [XW:0] t;
        t = ((XW+1)'(v) + RND) >>> GUARD;
        if (t < 0)    return '0;
        if (t > PEAK) return PEAK[DATA_WIDTH:0];
        return t[DATA_WIDTH:0];
    endfunction

    assign w_xsat = round_sat(r_x);
    assign w_ysat = round_sat(r_y);

    // Control FSM plus datapath and held output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_q     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_iter  <= '0;
            r_xo    <= '0;
            r_yo    <= '0;
            r_qo    <= '0;
            r_ov    <= 1'b0;
        end else begin
            r_ov <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (phase_valid && r_ready) begin
                        r_q     <= phase_in[PHASE_WIDTH-1 -: 2];
                        r_x     <= X0;
                        r_y     <= '0;
                        r_z     <= w_z0;
                        r_iter  <= '0;
                        r_ready <= 1'b0;
                        r_state <= ST_ROTATE;
                    end
                end
                ST_ROTATE: begin
                    r_x    <= w_xn;
                    r_y    <= w_yn;
                    r_z    <= w_zn;
                    r_iter <= r_iter + 1'b1;
                    if (r_iter == LAST) r_state <= ST_FINISH;
                end
                ST_FINISH: begin
                    r_xo    <= w_xsat;
                    r_yo    <= w_ysat;
                    r_qo    <= r_q;
                    r_ov    <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign phase_ready = r_ready;
    assign x_out       = r_xo;
    assign y_out       = r_yo;
    assign quarter_out = r_qo;
    assign out_valid   = r_ov;
endmodule

// File: tb/tb_cordic_rotator.sv
// Scoreboard bench for cordic_rotator: trig reference model, decoupled acceptance/result monitors.
module tb_cordic_rotator;
    localparam int DW = 12, PW = 16, IT = 12, G = 2;
    localparam real PI = 3.14159265358979;

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic [PW-1:0]        phase_in = '0;
    logic                 phase_valid = 1'b0;
    logic                 phase_ready;
    logic signed [DW:0]   x_out, y_out;
    logic [1:0]           quarter_out;
    logic                 out_valid;

    cordic_rotator #(.DATA_WIDTH(DW), .PHASE_WIDTH(PW), .ITERATIONS(IT), .GUARD(G)) dut (
        .clock(clock), .reset_n(reset_n), .phase_in(phase_in), .phase_valid(phase_valid),
        .phase_ready(phase_ready), .x_out(x_out), .y_out(y_out),
        .quarter_out(quarter_out), .out_valid(out_valid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [PW-1:0] ph;
        int            t;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0, passed = 0;
    int   cyc = 0, acc_cnt = 0, last_acc = -1;
    bit   stream_mode = 1'b0;
    bit   prev_ov = 1'b0;

    task automatic chk(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    endtask

    // Reference: ideal 2047*|cos|, 2047*|sin| of the full-turn angle, +/-3 LSB.
    function automatic int mag(input real v);
        real a;
        a = (v < 0.0) ? -v : v;
        return $rtoi(2047.0 * a + 0.5);
    endfunction

    task automatic chk_mag(input string name, input int act, input int ideal);
        int lo, hi;
        lo = (ideal - 3 < 0) ? 0 : ideal - 3;
        hi = (ideal + 3 > 2047) ? 2047 : ideal + 3;
        chk(name, act, lo, hi);
    endtask

    // Acceptance monitor: records each handshake and queues its expectation.
    initial forever begin
        @(posedge clock);
        if (reset_n && phase_valid && phase_ready) begin
            sbq.push_back('{ph: phase_in, t: cyc + 1});
            if (stream_mode && last_acc >= 0) chk("accept_spacing", cyc - last_acc, IT + 2, IT + 2);
            last_acc = cyc;
            acc_cnt++;
        end
        cyc++;
    end

    // Result monitor: pops and compares whenever out_valid is presented.
    initial forever begin
        @(negedge clock);
        if (out_valid) begin
            exp_t e;
            real  th;
            chk("strobe_width", int'(prev_ov), 0, 0);
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 1, 0, 0);
            end else begin
                e  = sbq.pop_front();
                th = 2.0 * PI * real'(e.ph) / 65536.0;
                chk_mag($sformatf("x_out[%h]", e.ph), int'(x_out), mag($cos(th)));
                chk_mag($sformatf("y_out[%h]", e.ph), int'(y_out), mag($sin(th)));
                chk($sformatf("quarter[%h]", e.ph), int'(quarter_out), int'(e.ph[PW-1 -: 2]), int'(e.ph[PW-1 -: 2]));
                chk($sformatf("latency[%h]", e.ph), cyc - e.t, IT + 1, IT + 1);
            end
        end
        prev_ov = out_valid;
    end

    task automatic send(input logic [PW-1:0] ph);
        int c0, n;
        @(negedge clock);
        phase_in    = ph;
        phase_valid = 1'b1;
        c0 = acc_cnt;
        n  = 0;
        while (acc_cnt == c0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (acc_cnt == c0) chk("accept_timeout", n, 0, 99);
        phase_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk("drain", sbq.size(), 0, 0);
    endtask

    initial begin
        logic [PW-1:0] dirs [4];
        int target, n;

        // Reset state.
        repeat (3) @(negedge clock);
        chk("rst_ready", int'(phase_ready), 0, 0);
        chk("rst_x", int'(x_out), 0, 0);
        chk("rst_y", int'(y_out), 0, 0);
        chk("rst_q", int'(quarter_out), 0, 0);
        chk("rst_ov", int'(out_valid), 0, 0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("ready_after_release", int'(phase_ready), 1, 1);

        // Directed points, including the r=0 fold at 90 degrees.
        dirs = '{16'h0000, 16'h4000, 16'hA000, 16'hD555};
        for (int i = 0; i < 4; i++) send(dirs[i]);
        drain();

        // Quadrant edges and random phases with random idle gaps.
        send(16'h3FFF); send(16'h8000); send(16'hC000); send(16'hFFFF);
        for (int i = 0; i < 24; i++) begin
            send(PW'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        drain();

        // phase_valid held high with a changing phase: only accepted words are consumed.
        stream_mode = 1'b1;
        last_acc    = -1;
        target      = acc_cnt + 5;
        n           = 0;
        @(negedge clock);
        phase_valid = 1'b1;
        while (acc_cnt < target && n < 200) begin
            phase_in = PW'($urandom);
            @(negedge clock);
            n++;
        end
        chk("stream_accepts", acc_cnt, target, target);
        phase_valid = 1'b0;
        stream_mode = 1'b0;
        drain();

        // Reset during iteration 5 aborts the result and clears outputs at once.
        send(16'h1234);
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_x", int'(x_out), 0, 0);
        chk("midrst_y", int'(y_out), 0, 0);
        chk("midrst_q", int'(quarter_out), 0, 0);
        chk("midrst_ov", int'(out_valid), 0, 0);
        chk("midrst_ready", int'(phase_ready), 0, 0);
        sbq.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (IT + 4) @(negedge clock);
        send(16'h6AAA);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
